rf_wb_arbiter: RTL

Write-port controller for the 32x32 register file. It shares the file's single write port (RF_W / write_addr / write_data) between two writeback requesters: req0 is ALU writeback and req1 is memory/load writeback. Ties are broken round-robin. It also runs a clear sweep that zeroes x1..x31 on command, and it suppresses writes to x0. It sits between the writeback stages and the register-file write port; read ports are not touched.

---
 rtl/rf_wb_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter with round-robin writeback and clear sweep
module rf_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          inclk,
  input  logic          rstn,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done,
  output logic          RF_W,
  output logic [AW-1:0] write_addr,
  output logic [DW-1:0] write_data
);

  typedef enum logic {ST_ARB, ST_CLEAR} state_t;

  localparam logic [AW-1:0] FIRST_ADDR = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] LAST_ADDR  = {AW{1'b1}};

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          last_grant, last_grant_nxt;
  logic          grant0, grant1;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    grant0         = 1'b0;
    grant1         = 1'b0;
    case (state)
      ST_ARB: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = FIRST_ADDR;
        end else begin
          // On a tie, req0 wins only if req1 won last
          grant0 = req0_valid && (!req1_valid || last_grant);
          grant1 = req1_valid && !grant0;
          if (grant0)
            last_grant_nxt = 1'b0;
          else if (grant1)
            last_grant_nxt = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (cnt == LAST_ADDR) begin
          state_nxt = ST_ARB;
          cnt_nxt   = FIRST_ADDR;
        end else begin
          cnt_nxt = cnt + FIRST_ADDR;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  assign req0_ready = rstn && grant0;
  assign req1_ready = rstn && grant1;
  assign busy       = (state == ST_CLEAR);

  always_ff @(posedge inclk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_ARB;
      cnt        <= FIRST_ADDR;
      last_grant <= 1'b1;
      RF_W       <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      clr_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      RF_W       <= 1'b0;
      clr_done   <= 1'b0;
      if (state == ST_CLEAR) begin
        RF_W       <= 1'b1;
        write_addr <= cnt;
        write_data <= '0;
        clr_done   <= (cnt == LAST_ADDR);
      end else if (grant0) begin
        // x0 transfers are consumed without touching the write port
        if (req0_addr != '0) begin
          RF_W       <= 1'b1;
          write_addr <= req0_addr;
          write_data <= req0_data;
        end
      end else if (grant1) begin
        if (req1_addr != '0) begin
          RF_W       <= 1'b1;
          write_addr <= req1_addr;
          write_data <= req1_data;
        end
      end
    end
  end

endmodule
